output_image_dma: RTL

Output-scan DMA channel for the PLC CPU: the reading counterpart of the input-scan channel that fills the image memory. On request it reads the output region of the bit-wide image memory, one bit per cycle, into a shadow register. It then updates the physical output word in a single atomic commit, so outputs never show a half-updated scan. It sits between image memory port 0 and the output pins, and is started once per PLC cycle by the scan sequencer.

---
 rtl/output_image_dma_if.sv | 32 +++
 rtl/output_image_dma.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/output_image_dma_if.sv
// Output-scan DMA bus: scan control from the sequencer, image-memory read
// port, and the committed output word.
//   start/abort : scan request / cancel (sequencer -> DMA)
//   mem_a/mem_re: image memory read address / strobe (DMA -> memory)
//   mem_dq      : image memory read data (memory -> DMA)
//   out         : committed output word (DMA -> pins)
//   busy/done   : scan in progress / one-cycle commit pulse (DMA -> sequencer)
interface output_image_dma_if #(
   parameter int unsigned N_BITS = 16,
   parameter int unsigned ADDR_W = 5
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_re;
   logic              mem_dq;
   logic [N_BITS-1:0] out;
   logic              busy;
   logic              done;

   // Sequencer plus image memory side.
   modport master (
      output start, abort, mem_dq,
      input  mem_a, mem_re, out, busy, done
   );

   // DMA channel side.
   modport slave (
      input  start, abort, mem_dq,
      output mem_a, mem_re, out, busy, done
   );
endinterface

// File: rtl/output_image_dma.sv
// Output-scan DMA channel: reads N_BITS bits of the image memory starting at
// OUT_BASE, one per cycle, into a shadow register, then copies the shadow to
// the output word in a single edge so the pins never show a partial scan.
//   clk   : rising-edge clock
//   clr   : asynchronous active-low reset, forces all outputs off
//   bus   : output_image_dma_if.slave (start/abort in, memory read port,
//           out/busy/done out); all outputs are registered
module output_image_dma #(
   parameter int unsigned N_BITS   = 16,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned OUT_BASE = 16,
   parameter int unsigned RD_LAT   = 1
) (
   input logic                clk,
   input logic                clr,
   output_image_dma_if.slave  bus
);

   localparam int unsigned IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int unsigned CNT_W = $clog2(N_BITS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [ADDR_W-1:0]  mem_a, mem_a_d;
   logic               mem_re, mem_re_d;
   logic [N_BITS-1:0]  out_q, out_d;
   logic [N_BITS-1:0]  shadow, shadow_d;
   logic               done, done_d;
   logic               busy, busy_d;

   // Read-tag pipeline: one stage per cycle of memory latency.
   logic [RD_LAT-1:0]            vld_pipe;
   logic [RD_LAT-1:0][IDX_W-1:0] idx_pipe;

   logic              flush_c;
   logic              cap_c;
   logic              last_cap_c;
   logic [IDX_W-1:0]  cap_idx_c;
   logic [IDX_W-1:0]  issue_idx_c;

   // COMMIT is excluded: the commit edge is already decided and completes.
   assign flush_c     = bus.abort && ((state == READ) || (state == DRAIN));
   assign cap_idx_c   = idx_pipe[RD_LAT-1];
   assign cap_c       = vld_pipe[RD_LAT-1] && !flush_c;
   assign last_cap_c  = cap_c && (cap_idx_c == IDX_W'(N_BITS - 1));
   assign issue_idx_c = IDX_W'(mem_a - ADDR_W'(OUT_BASE));

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      mem_a_d  = mem_a;
      mem_re_d = 1'b0;
      out_d    = out_q;
      shadow_d = shadow;
      done_d   = 1'b0;

      if (cap_c) begin
         shadow_d[cap_idx_c] = bus.mem_dq;
      end

      unique case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d  = READ;
               mem_re_d = 1'b1;
               mem_a_d  = ADDR_W'(OUT_BASE);
               cnt_d    = CNT_W'(1);
            end
         end
         READ: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (cnt == CNT_W'(N_BITS)) begin
               state_d = DRAIN;
            end else begin
               mem_re_d = 1'b1;
               mem_a_d  = mem_a + ADDR_W'(1);
               cnt_d    = cnt + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (last_cap_c) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            out_d   = shadow;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         cnt    <= '0;
         mem_a  <= '0;
         mem_re <= 1'b0;
         out_q  <= '0;
         shadow <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         mem_a  <= mem_a_d;
         mem_re <= mem_re_d;
         out_q  <= out_d;
         shadow <= shadow_d;
         done   <= done_d;
         busy   <= busy_d;
      end
   end

   // Tag pipeline: follows the issued strobe by RD_LAT edges; abort empties it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else if (flush_c) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= mem_re;
         idx_pipe[0] <= issue_idx_c;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

   assign bus.mem_a  = mem_a;
   assign bus.mem_re = mem_re;
   assign bus.out    = out_q;
   assign bus.busy   = busy;
   assign bus.done   = done;

endmodule
